// File: rtl/cci_mpf_csr_evt_pkg.sv
// Shared types and helpers for the MPF CSR event-counter bank.
//   t_cci_mpf_evt_idx  : counter index as carried on clear/read ports
//   t_cci_mpf_evt_rsp  : 64-bit read response word, overflow flag in bit 63
//   cci_mpf_evt_pack_rsp: builds a response word from a zero-extended count
package cci_mpf_csr_evt_pkg;

    localparam int CCI_MPF_EVT_MAX_EVENTS = 64;
    // Read pipeline depth: request capture, one transport stage, output stage.
    localparam int CCI_MPF_EVT_RD_LAT     = 3;

    typedef logic [5:0] t_cci_mpf_evt_idx;

    // The count field is wider than any counter; the top zero-extends,
    // so bits above COUNTER_WIDTH act as the zero pad.
    typedef struct packed {
        logic        ovf;
        logic [62:0] count;
    } t_cci_mpf_evt_rsp;

    function automatic t_cci_mpf_evt_rsp cci_mpf_evt_pack_rsp(
        input logic [62:0] count,
        input logic        ovf
    );
        t_cci_mpf_evt_rsp rsp;
        rsp.ovf   = ovf;
        rsp.count = count;
        return rsp;
    endfunction

endpackage

// File: rtl/cci_mpf_event_counter.sv
// Single event counter with sticky overflow.
//   clk, reset : clock, async active-high reset
//   inc        : registered per-cycle increment
//   clr        : clear; the concurrent increment is kept as the new count
//   cnt, ovf   : current count and sticky overflow flag
module cci_mpf_event_counter
    import cci_mpf_csr_evt_pkg::*;
#(
    parameter int COUNTER_WIDTH = 48,
    parameter int INC_WIDTH     = 2,
    parameter int SATURATE      = 0
)(
    input  logic                     clk,
    input  logic                     reset,
    input  logic [INC_WIDTH-1:0]     inc,
    input  logic                     clr,
    output logic [COUNTER_WIDTH-1:0] cnt,
    output logic                     ovf
);

    localparam int SUM_W = COUNTER_WIDTH + 1;

    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic                     ovf_q, ovf_d;
    logic [SUM_W-1:0]         sum;

    always_comb begin
        // Extra top bit of the sum is the carry-out, i.e. overflow.
        sum   = {1'b0, cnt_q} + SUM_W'(inc);
        cnt_d = sum[COUNTER_WIDTH-1:0];
        ovf_d = ovf_q;
        if (clr) begin
            cnt_d = COUNTER_WIDTH'(inc);
            ovf_d = 1'b0;
        end else if (sum[COUNTER_WIDTH]) begin
            ovf_d = 1'b1;
            if (SATURATE != 0) begin
                cnt_d = '1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt = cnt_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/cci_mpf_csr_event_counters.sv
// Event-counter bank for the MPF CSR manager.
//   clk, reset          : clock, async active-high reset
//   ev_inc              : per-event increments, event i at [i*INC_WIDTH +: INC_WIDTH]
//   clr_all             : clear every counter and overflow flag
//   clr_valid, clr_idx  : clear a single counter (out-of-range index ignored)
//   snap_req            : atomically copy live counters/flags to the snapshot bank
//   rd_req, rd_idx,
//   rd_snap             : indexed read of live (0) or snapshot (1) bank
//   rd_rsp_valid/data   : response two edges after the request is sampled
//   any_ovf             : registered OR of live overflow flags
module cci_mpf_csr_event_counters
    import cci_mpf_csr_evt_pkg::*;
#(
    parameter int N_EVENTS      = 16,
    parameter int COUNTER_WIDTH = 48,
    parameter int INC_WIDTH     = 2,
    parameter int SATURATE      = 0
)(
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_EVENTS*INC_WIDTH-1:0] ev_inc,
    input  logic                          clr_all,
    input  logic                          clr_valid,
    input  t_cci_mpf_evt_idx              clr_idx,
    input  logic                          snap_req,
    input  logic                          rd_req,
    input  t_cci_mpf_evt_idx              rd_idx,
    input  logic                          rd_snap,
    output logic                          rd_rsp_valid,
    output logic [63:0]                   rd_rsp_data,
    output logic                          any_ovf
);

    localparam int N_EV   = (N_EVENTS < CCI_MPF_EVT_MAX_EVENTS) ? N_EVENTS : CCI_MPF_EVT_MAX_EVENTS;
    localparam int RD_LAT = CCI_MPF_EVT_RD_LAT;

    logic [N_EVENTS*INC_WIDTH-1:0] ev_q, ev_d;
    logic [COUNTER_WIDTH-1:0]      cnt [N_EV];
    logic [N_EV-1:0]               ovf;
    logic [N_EV-1:0]               clr;

    logic [COUNTER_WIDTH-1:0]      snap_cnt_q [N_EV];
    logic [COUNTER_WIDTH-1:0]      snap_cnt_d [N_EV];
    logic [N_EV-1:0]               snap_ovf_q, snap_ovf_d;

    t_cci_mpf_evt_rsp              rd_sel;
    logic [RD_LAT-1:0]             rd_vld_q, rd_vld_d;
    t_cci_mpf_evt_rsp              rd_data_q [RD_LAT];
    t_cci_mpf_evt_rsp              rd_data_d [RD_LAT];
    logic                          any_ovf_q, any_ovf_d;

    for (genvar i = 0; i < N_EV; i++) begin : g_cnt
        assign clr[i] = clr_all | (clr_valid & (clr_idx == 6'(i)));

        cci_mpf_event_counter #(
            .COUNTER_WIDTH (COUNTER_WIDTH),
            .INC_WIDTH     (INC_WIDTH),
            .SATURATE      (SATURATE)
        ) u_cnt (
            .clk   (clk),
            .reset (reset),
            .inc   (ev_q[i*INC_WIDTH +: INC_WIDTH]),
            .clr   (clr[i]),
            .cnt   (cnt[i]),
            .ovf   (ovf[i])
        );
    end

    always_comb begin
        ev_d       = ev_inc;
        // Snapshot takes the pre-edge values, so a same-cycle clear does not
        // reach the snapshot bank.
        snap_ovf_d = snap_req ? ovf : snap_ovf_q;
        for (int i = 0; i < N_EV; i++) begin
            snap_cnt_d[i] = snap_req ? cnt[i] : snap_cnt_q[i];
        end

        // Unmatched (out-of-range) indices fall through to zero.
        rd_sel = '0;
        for (int i = 0; i < N_EV; i++) begin
            if (rd_idx == 6'(i)) begin
                rd_sel = rd_snap ? cci_mpf_evt_pack_rsp(63'(snap_cnt_q[i]), snap_ovf_q[i])
                                 : cci_mpf_evt_pack_rsp(63'(cnt[i]), ovf[i]);
            end
        end

        rd_vld_d     = {rd_vld_q[RD_LAT-2:0], rd_req};
        rd_data_d[0] = rd_req ? rd_sel : '0;
        for (int s = 1; s < RD_LAT; s++) begin
            rd_data_d[s] = rd_data_q[s-1];
        end

        any_ovf_d = |ovf;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ev_q       <= '0;
            snap_ovf_q <= '0;
            rd_vld_q   <= '0;
            any_ovf_q  <= 1'b0;
            for (int i = 0; i < N_EV; i++) begin
                snap_cnt_q[i] <= '0;
            end
            for (int s = 0; s < RD_LAT; s++) begin
                rd_data_q[s] <= '0;
            end
        end else begin
            ev_q       <= ev_d;
            snap_ovf_q <= snap_ovf_d;
            rd_vld_q   <= rd_vld_d;
            any_ovf_q  <= any_ovf_d;
            for (int i = 0; i < N_EV; i++) begin
                snap_cnt_q[i] <= snap_cnt_d[i];
            end
            for (int s = 0; s < RD_LAT; s++) begin
                rd_data_q[s] <= rd_data_d[s];
            end
        end
    end

    assign rd_rsp_valid = rd_vld_q[RD_LAT-1];
    assign rd_rsp_data  = rd_data_q[RD_LAT-1];
    assign any_ovf      = any_ovf_q;

endmodule

// File: tb/tb_cci_mpf_csr_event_counters.sv
module tb_cci_mpf_csr_event_counters;

    localparam int N  = 16;
    localparam int CW = 8;
    localparam int IW = 2;
    localparam int unsigned CMAX = 255;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N*IW-1:0] ev_inc = '0;
    logic            clr_all = 1'b0, clr_valid = 1'b0, snap_req = 1'b0;
    logic            rd_req = 1'b0, rd_snap = 1'b0;
    logic [5:0]      clr_idx = '0, rd_idx = '0;

    logic            vld0, vld1, any0, any1;
    logic [63:0]     dat0, dat1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Instance 0 wraps, instance 1 saturates; both see identical stimulus.
    cci_mpf_csr_event_counters #(
        .N_EVENTS(N), .COUNTER_WIDTH(CW), .INC_WIDTH(IW), .SATURATE(0)
    ) u_wrap (
        .clk(clk), .reset(rst), .ev_inc(ev_inc),
        .clr_all(clr_all), .clr_valid(clr_valid), .clr_idx(clr_idx),
        .snap_req(snap_req), .rd_req(rd_req), .rd_idx(rd_idx), .rd_snap(rd_snap),
        .rd_rsp_valid(vld0), .rd_rsp_data(dat0), .any_ovf(any0)
    );

    cci_mpf_csr_event_counters #(
        .N_EVENTS(N), .COUNTER_WIDTH(CW), .INC_WIDTH(IW), .SATURATE(1)
    ) u_sat (
        .clk(clk), .reset(rst), .ev_inc(ev_inc),
        .clr_all(clr_all), .clr_valid(clr_valid), .clr_idx(clr_idx),
        .snap_req(snap_req), .rd_req(rd_req), .rd_idx(rd_idx), .rd_snap(rd_snap),
        .rd_rsp_valid(vld1), .rd_rsp_data(dat1), .any_ovf(any1)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int unsigned m_cnt [2][N];
    bit          m_ovf [2][N];
    int unsigned m_snc [2][N];
    bit          m_sno [2][N];
    int unsigned m_evq [N];

    typedef struct {
        int          due;
        logic [63:0] d0;
        logic [63:0] d1;
    } rsp_t;
    rsp_t rq[$];

    int          cyc = 0;
    bit          e_vld = 1'b0;
    logic [63:0] e_d0 = '0, e_d1 = '0;
    bit          e_any0 = 1'b0, e_any1 = 1'b0;

    function automatic logic [63:0] m_read(input int s, input int idx, input bit snap);
        logic [63:0] r = 64'd0;
        if (idx < N) begin
            r     = 64'(snap ? m_snc[s][idx] : m_cnt[s][idx]);
            r[63] = snap ? m_sno[s][idx] : m_ovf[s][idx];
        end
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < 2; s++) begin
                for (int i = 0; i < N; i++) begin
                    m_cnt[s][i] = 0; m_ovf[s][i] = 0;
                    m_snc[s][i] = 0; m_sno[s][i] = 0;
                end
            end
            for (int i = 0; i < N; i++) m_evq[i] = 0;
            rq.delete();
            e_vld = 0; e_d0 = '0; e_d1 = '0; e_any0 = 0; e_any1 = 0;
        end else begin
            rsp_t r;
            bit   clear;
            int unsigned sum;
            cyc++;
            e_vld = 0; e_d0 = '0; e_d1 = '0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                e_vld = 1; e_d0 = rq[0].d0; e_d1 = rq[0].d1;
                void'(rq.pop_front());
            end
            e_any0 = 0; e_any1 = 0;
            for (int i = 0; i < N; i++) begin
                e_any0 |= m_ovf[0][i];
                e_any1 |= m_ovf[1][i];
            end
            if (rd_req) begin
                r.due = cyc + 2;
                r.d0  = m_read(0, int'(rd_idx), rd_snap);
                r.d1  = m_read(1, int'(rd_idx), rd_snap);
                rq.push_back(r);
            end
            for (int s = 0; s < 2; s++) begin
                for (int i = 0; i < N; i++) begin
                    if (snap_req) begin
                        m_snc[s][i] = m_cnt[s][i];
                        m_sno[s][i] = m_ovf[s][i];
                    end
                    clear = clr_all || (clr_valid && int'(clr_idx) == i);
                    if (clear) begin
                        m_cnt[s][i] = m_evq[i];
                        m_ovf[s][i] = 0;
                    end else begin
                        sum = m_cnt[s][i] + m_evq[i];
                        if (sum > CMAX) begin
                            m_ovf[s][i] = 1;
                            m_cnt[s][i] = (s == 1) ? CMAX : sum - (CMAX + 1);
                        end else begin
                            m_cnt[s][i] = sum;
                        end
                    end
                end
            end
            for (int i = 0; i < N; i++) m_evq[i] = int'(ev_inc[i*IW +: IW]);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        check("rsp_valid_wrap", 64'(vld0), 64'(e_vld));
        check("rsp_valid_sat",  64'(vld1), 64'(e_vld));
        check("any_ovf_wrap",   64'(any0), 64'(e_any0));
        check("any_ovf_sat",    64'(any1), 64'(e_any1));
        if (e_vld) begin
            check("rsp_data_wrap", dat0, e_d0);
            check("rsp_data_sat",  dat1, e_d1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ev(input int i, input int v);
        ev_inc[i*IW +: IW] = IW'(v);
    endtask

    task automatic do_read(input int idx, input bit snap,
                           output logic [63:0] d0, output logic [63:0] d1);
        int n;
        @(negedge clk);
        rd_req = 1'b1; rd_idx = 6'(idx); rd_snap = snap;
        @(negedge clk);
        rd_req = 1'b0;
        n = 1;
        while (!vld0 && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("rd_latency", 64'(n), 64'd3);
        d0 = dat0;
        d1 = dat1;
    endtask

    initial begin
        logic [63:0] a, b;
        logic [7:0]  vpat;
        logic [63:0] got [8];
        int          ids [4];
        int          nv;

        #1 rst = 1'b1;
        tick(3);
        check("reset_valid", 64'(vld0 | vld1), 64'd0);
        check("reset_data",  dat0 | dat1, 64'd0);
        check("reset_any",   64'(any0 | any1), 64'd0);
        rst = 1'b0;
        tick(2);

        // Ten single increments on event 0.
        set_ev(0, 1); tick(10); set_ev(0, 0); tick(2);
        do_read(0, 1'b0, a, b);
        check("ev0_count10_wrap", a, 64'd10);
        check("ev0_count10_sat",  b, 64'd10);

        // 300 increments on an 8-bit counter.
        set_ev(3, 1); tick(300); set_ev(3, 0); tick(2);
        do_read(3, 1'b0, a, b);
        check("ovf_wrap_44",  a, 64'h8000_0000_0000_002C);
        check("ovf_sat_255",  b, 64'h8000_0000_0000_00FF);
        check("any_ovf_set",  64'({any0, any1}), 64'd3);

        // Clear with an increment in flight; out-of-range clear ignored.
        set_ev(2, 3); tick(4);
        set_ev(2, 0); clr_valid = 1'b1; clr_idx = 6'd2; tick(1);
        clr_idx = 6'd40; tick(1);
        clr_valid = 1'b0; tick(2);
        do_read(2, 1'b0, a, b);
        check("clr_keeps_inflight_wrap", a, 64'd3);
        check("clr_keeps_inflight_sat",  b, 64'd3);
        do_read(3, 1'b0, a, b);
        check("clr_oob_ignored", a, 64'h8000_0000_0000_002C);
        do_read(0, 1'b0, a, b);
        check("clr_other_untouched", a, 64'd10);
        clr_valid = 1'b1; clr_idx = 6'd3; tick(1);
        clr_valid = 1'b0; tick(2);
        check("any_ovf_cleared", 64'({any0, any1}), 64'd0);

        // Snapshot versus live bank.
        clr_all = 1'b1; tick(1); clr_all = 1'b0;
        set_ev(0, 1); set_ev(1, 1); tick(5);
        set_ev(0, 0); tick(2);
        set_ev(1, 0); tick(3);
        snap_req = 1'b1; tick(1); snap_req = 1'b0;
        set_ev(0, 1); set_ev(1, 1); tick(4);
        set_ev(0, 0); set_ev(1, 0); tick(3);
        do_read(0, 1'b1, a, b); check("snap0_5",  a, 64'd5);
        do_read(1, 1'b1, a, b); check("snap1_7",  a, 64'd7);
        do_read(0, 1'b0, a, b); check("live0_9",  a, 64'd9);
        do_read(1, 1'b0, a, b); check("live1_11", a, 64'd11);

        // Snapshot and clear_all on the same edge, increments in flight.
        set_ev(0, 2); set_ev(1, 1); tick(1);
        set_ev(0, 0); set_ev(1, 0); snap_req = 1'b1; clr_all = 1'b1; tick(1);
        snap_req = 1'b0; clr_all = 1'b0; tick(2);
        do_read(0, 1'b1, a, b); check("snapclr_snap0_9",  a, 64'd9);
        do_read(1, 1'b1, a, b); check("snapclr_snap1_11", a, 64'd11);
        do_read(0, 1'b0, a, b); check("snapclr_live0_2",  a, 64'd2);
        do_read(1, 1'b0, a, b); check("snapclr_live1_1",  a, 64'd1);

        // Counter 15 nonzero so an aliased index 63 would show up.
        set_ev(15, 3); tick(1); set_ev(15, 0); tick(3);

        // Back-to-back reads.
        ids[0] = 0; ids[1] = 1; ids[2] = 2; ids[3] = 63;
        vpat = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            vpat[k] = vld0;
            got[k]  = dat0;
            rd_req  = (k < 4);
            if (k < 4) rd_idx = 6'(ids[k]);
            rd_snap = 1'b0;
        end
        rd_req = 1'b0;
        check("b2b_valid_pattern", 64'(vpat), 64'h78);
        check("b2b_idx0",  got[3], 64'd2);
        check("b2b_idx1",  got[4], 64'd1);
        check("b2b_idx2",  got[5], 64'd0);
        check("b2b_idx63", got[6], 64'd0);

        // Async reset while a read is in flight.
        @(negedge clk);
        rd_req = 1'b1; rd_idx = 6'd15; rd_snap = 1'b0;
        @(negedge clk);
        rd_req = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        tick(3);
        rst = 1'b0;
        nv = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (vld0 || vld1) nv++;
        end
        check("reset_drops_rsp", 64'(nv), 64'd0);
        for (int i = 0; i < N; i++) begin
            do_read(i, 1'b0, a, b);
            check("post_reset_live", a | b, 64'd0);
        end
        do_read(1, 1'b1, a, b);
        check("post_reset_snap", a | b, 64'd0);

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
